data_memory_arbiter: RTL and testbench
======================================

DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, meaning: consecutive cycles port 1 may be denied before it is forced to win.
REQ-002 Parameter ADDR_W, default 32, meaning: address width passed to the memory unchanged.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-low.
REQ-005 req0_i  input  1  port 0 (CPU MEM stage) request.
REQ-006 we0_i  input  1  port 0 write enable (1=write, 0=read).
REQ-007 addr0_i  input  ADDR_W  port 0 address.
REQ-008 wdata0_i  input  32  port 0 write data.
REQ-009 gnt0_o  output  1  port 0 granted this cycle (combinational).
REQ-010 ack0_o  output  1  port 0 transaction completed last cycle (registered).
REQ-011 rdata0_o  output  32  port 0 read data, valid when ack0_o=1 for a read.
REQ-012 req1_i, we1_i, addr1_i, wdata1_i, gnt1_o, ack1_o, rdata1_o: the same as REQ-005..REQ-011, for port 1 (loader/DMA).
REQ-013 mem_addr_o  output  ADDR_W  address to the data memory.
REQ-014 mem_we_o  output  1  write strobe to the data memory.
REQ-015 mem_wdata_o  output  32  write data to the data memory.
REQ-016 mem_rdata_i  input  32  combinational read data from the data memory.

Function
REQ-017 At most one grant per cycle; gnt0_o and gnt1_o SHALL never both be 1.
- Default priority: port 0.
- Port 1 wins when only port 1 requests, or when starve_cnt == STARVE_LIMIT and req1_i=1.
REQ-018 The granted port's we/addr/wdata SHALL drive mem_*_o in the grant cycle.
- No grant: mem_we_o=0; mem_addr_o/mem_wdata_o hold their last granted values.
REQ-019 The memory write SHALL occur at the clock edge ending the grant cycle; latency is 1 cycle.
REQ-020 On a granted read, mem_rdata_i SHALL be registered into that port's rdata register at the cycle end.
- ackN_o=1 for exactly the following cycle, for both reads and writes.
- rdataN_o holds its value until that port's next granted read.
REQ-021 starve_cnt (width clog2(STARVE_LIMIT+1)):
- increments, saturating at STARVE_LIMIT, each cycle req1_i=1 and gnt1_o=0;
- clears to 0 on gnt1_o=1 or req1_i=0.
REQ-022 A requester SHALL hold req/we/addr/wdata stable until granted; the arbiter does not latch ungranted requests.
- Dropping a request before grant is legal and simply cancels it.
REQ-023 Back-to-back grants to the same port on consecutive cycles SHALL be supported with no bubble.
REQ-024 With STARVE_LIMIT=0, port 1 SHALL win every contended cycle (port 1 priority).

Reset
REQ-025 While rst_i=0 at a clock edge, the arbiter SHALL clear ack0_o, ack1_o, rdata0_o, rdata1_o, starve_cnt and the held mem_addr_o/mem_wdata_o to 0.
REQ-026 While rst_i=0, gnt0_o, gnt1_o and mem_we_o SHALL be forced to 0, so no memory write occurs.
REQ-027 A transaction granted in the cycle before reset asserts SHALL still write memory (if a write), but its ack SHALL be suppressed.
REQ-028 The first cycle after rst_i returns to 1 SHALL arbitrate normally with starve_cnt=0.

Structure
REQ-029 Package data_mem_arb_pkg SHALL hold the STARVE_LIMIT default, port index constants PORT_CPU=0 and PORT_DMA=1, and the data width constant 32.
REQ-030 The starvation counter SHALL be a sub-module, starve_counter (inputs: req, gnt, rst; output: force).
- The grant mux and ack/rdata registers stay in the top module.

Verification
REQ-031 Reset: hold rst_i=0 for 2 cycles with req0_i=we0_i=1 -> mem_we_o=0, gnt=0, ack=0, rdata=0 throughout.
REQ-032 Solo read: port 1 reads addr 5 (memory[5]=0xDEAD_BEEF) -> gnt1_o=1 in cycle N; ack1_o=1 and rdata1_o=0xDEADBEEF in cycle N+1.
REQ-033 Contention: req0_i and req1_i held high 6 cycles -> port 0 granted cycles 0-3, port 1 granted cycle 4, port 0 granted cycle 5.
REQ-034 Write then read: port 0 writes 0x1234 to addr 10, then reads addr 10 the next cycle -> both granted back-to-back; second ack0_o returns 0x1234.
REQ-035 Reset mid-operation: grant a port 0 write of 0x55 to addr 3, then assert rst_i the next cycle -> memory[3]=0x55 and ack0_o stays 0.
REQ-036 STARVE_LIMIT=0 build with both ports requesting -> gnt1_o=1 every cycle and gnt0_o=0.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// Shared constants and types for the two-port data memory arbiter.
package data_mem_arb_pkg;

   localparam int STARVE_LIMIT_DEFAULT = 4;
   localparam int DATA_W = 32;

   // Port indices: the CPU MEM stage is port 0, the loader/DMA engine is port 1.
   typedef enum logic {
      PORT_CPU = 1'b0,
      PORT_DMA = 1'b1
   } port_e;

   // Width of the starvation counter; a limit of 0 still needs one bit.
   function automatic int starve_cnt_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/starve_counter.sv
// Counts consecutive cycles the DMA port is denied and forces it to win
// once the limit is reached.
module starve_counter
   import data_mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic req,
   input  logic gnt,
   output logic force_win
);

   localparam int CW = starve_cnt_width(STARVE_LIMIT);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] starve_cnt;

   // Saturating count of denied cycles; any grant or dropped request restarts it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (req && !gnt) begin
         if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + CW'(1);
         end
      end else begin
         starve_cnt <= '0;
      end
   end

   assign force_win = req && (starve_cnt == LIMIT);

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter in front of a single-ported data memory: CPU port has
// priority, the DMA port is protected from starvation.
module data_memory_arbiter
   import data_mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
   parameter int ADDR_W       = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req0_i,
   input  logic              we0_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [DATA_W-1:0] wdata0_i,
   output logic              gnt0_o,
   output logic              ack0_o,
   output logic [DATA_W-1:0] rdata0_o,
   input  logic              req1_i,
   input  logic              we1_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [DATA_W-1:0] wdata1_i,
   output logic              gnt1_o,
   output logic              ack1_o,
   output logic [DATA_W-1:0] rdata1_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_we_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   logic              force_dma;
   logic              ack0_q;
   logic              ack1_q;
   logic [ADDR_W-1:0] held_addr;
   logic [DATA_W-1:0] held_wdata;

   starve_counter #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_starve_counter (
      .clk      (clk_i),
      .rst      (rst_i),
      .req      (req1_i),
      .gnt      (gnt1_o),
      .force_win(force_dma)
   );

   // Pick at most one winner; DMA wins when alone or when it has waited too long.
   always_comb begin
      gnt0_o = 1'b0;
      gnt1_o = 1'b0;
      if (rst_i) begin
         if (req1_i && (!req0_i || force_dma)) begin
            gnt1_o = 1'b1;
         end else if (req0_i) begin
            gnt0_o = 1'b1;
         end
      end
   end

   // Route the winner to memory; idle cycles keep the last address/data and never write.
   always_comb begin
      mem_we_o    = 1'b0;
      mem_addr_o  = held_addr;
      mem_wdata_o = held_wdata;
      if (gnt0_o) begin
         mem_we_o    = we0_i;
         mem_addr_o  = addr0_i;
         mem_wdata_o = wdata0_i;
      end else if (gnt1_o) begin
         mem_we_o    = we1_i;
         mem_addr_o  = addr1_i;
         mem_wdata_o = wdata1_i;
      end
   end

   // Register completion flags, captured read data and the held memory bus values.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         rdata0_o   <= '0;
         rdata1_o   <= '0;
         held_addr  <= '0;
         held_wdata <= '0;
      end else begin
         ack0_q <= gnt0_o;
         ack1_q <= gnt1_o;
         if (gnt0_o || gnt1_o) begin
            held_addr  <= mem_addr_o;
            held_wdata <= mem_wdata_o;
         end
         if (gnt0_o && !we0_i) begin
            rdata0_o <= mem_rdata_i;
         end
         if (gnt1_o && !we1_i) begin
            rdata1_o <= mem_rdata_i;
         end
      end
   end

   // A grant completing just as reset arrives still writes memory, but its
   // ack must not be seen, so the registered ack is masked while in reset.
   assign ack0_o = ack0_q & rst_i;
   assign ack1_o = ack1_q & rst_i;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter with a behavioural reference model.
module tb_data_memory_arbiter;
   import data_mem_arb_pkg::*;

   localparam int LIMIT = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req0_i, we0_i, req1_i, we1_i;
   logic [31:0] addr0_i, wdata0_i, addr1_i, wdata1_i;

   logic        gnt0_o, ack0_o, gnt1_o, ack1_o, memWe;
   logic [31:0] rdata0_o, rdata1_o, memAddr, memWdata, memRdata;

   logic        gnt0Z, ack0Z, gnt1Z, ack1Z, memWeZ;
   logic [31:0] rdata0Z, rdata1Z, memAddrZ, memWdataZ, memRdataZ;

   logic [31:0] benchMem [0:255];
   logic [31:0] refMem   [0:255];

   int vectors = 0;
   int miscompares = 0;

   // Reference model state, described in terms of observable behaviour.
   int          waitCnt;
   bit          prevG0, prevG1;
   logic [31:0] eRd0, eRd1, eHeldA, eHeldD;
   bit          eg0, eg1, eWe, eAck0, eAck1;
   logic [31:0] eAddr, eWdata;

   data_memory_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req0_i(req0_i), .we0_i(we0_i), .addr0_i(addr0_i), .wdata0_i(wdata0_i),
      .gnt0_o(gnt0_o), .ack0_o(ack0_o), .rdata0_o(rdata0_o),
      .req1_i(req1_i), .we1_i(we1_i), .addr1_i(addr1_i), .wdata1_i(wdata1_i),
      .gnt1_o(gnt1_o), .ack1_o(ack1_o), .rdata1_o(rdata1_o),
      .mem_addr_o(memAddr), .mem_we_o(memWe), .mem_wdata_o(memWdata),
      .mem_rdata_i(memRdata)
   );

   data_memory_arbiter #(.STARVE_LIMIT(0), .ADDR_W(32)) dutZero (
      .clk_i(clk_i), .rst_i(rst_i),
      .req0_i(req0_i), .we0_i(we0_i), .addr0_i(addr0_i), .wdata0_i(wdata0_i),
      .gnt0_o(gnt0Z), .ack0_o(ack0Z), .rdata0_o(rdata0Z),
      .req1_i(req1_i), .we1_i(we1_i), .addr1_i(addr1_i), .wdata1_i(wdata1_i),
      .gnt1_o(gnt1Z), .ack1_o(ack1Z), .rdata1_o(rdata1Z),
      .mem_addr_o(memAddrZ), .mem_we_o(memWeZ), .mem_wdata_o(memWdataZ),
      .mem_rdata_i(memRdataZ)
   );

   // Free-running clock.
   always #5 clk_i = ~clk_i;

   // Combinational-read data memory seen by the arbiters.
   assign memRdata  = benchMem[memAddr[7:0]];
   assign memRdataZ = benchMem[memAddrZ[7:0]];

   // Memory write at the edge ending the grant cycle.
   always @(posedge clk_i) begin
      if (memWe) benchMem[memAddr[7:0]] <= memWdata;
   end

   task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
      req0_i = r0; we0_i = w0; addr0_i = a0; wdata0_i = d0;
      req1_i = r1; we1_i = w1; addr1_i = a1; wdata1_i = d1;
   endtask

   // Expected outputs for the current cycle from the arbitration rules.
   task automatic predict();
      if (!rst_i) begin
         eg0 = 1'b0;
         eg1 = 1'b0;
      end else begin
         eg1 = req1_i && (!req0_i || waitCnt >= LIMIT);
         eg0 = req0_i && !eg1;
      end
      eWe    = eg0 ? we0_i : (eg1 ? we1_i : 1'b0);
      eAddr  = eg0 ? addr0_i : (eg1 ? addr1_i : eHeldA);
      eWdata = eg0 ? wdata0_i : (eg1 ? wdata1_i : eHeldD);
      eAck0  = prevG0 && rst_i;
      eAck1  = prevG1 && rst_i;
   endtask

   // Clock edge, then advance the reference model by one cycle.
   task automatic advance();
      @(posedge clk_i);
      if (!rst_i) begin
         waitCnt = 0; prevG0 = 0; prevG1 = 0;
         eRd0 = '0; eRd1 = '0; eHeldA = '0; eHeldD = '0;
      end else begin
         if (eg0 || eg1) begin
            eHeldA = eAddr;
            eHeldD = eWdata;
            if (eWe) refMem[eAddr[7:0]] = eWdata;
            else if (eg0) eRd0 = refMem[eAddr[7:0]];
            else eRd1 = refMem[eAddr[7:0]];
         end
         prevG0 = eg0;
         prevG1 = eg1;
         waitCnt = (req1_i && !eg1) ? waitCnt + 1 : 0;
      end
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      drive(1, 1, 32'd7, 32'hAAAA, 0, 0, 0, 0);
      for (int c = 0; c < 2; c++) begin
         predict();
         @(negedge clk_i);
         vectors++;
         if ({gnt0_o, gnt1_o} !== 2'b00) begin
            miscompares++; $display("[TB] FAIL reset_gnt: got %b required 00", {gnt0_o, gnt1_o});
         end
         vectors++;
         if (memWe !== 1'b0) begin
            miscompares++; $display("[TB] FAIL reset_mem_we: got %b required 0", memWe);
         end
         vectors++;
         if ({ack0_o, ack1_o} !== 2'b00) begin
            miscompares++; $display("[TB] FAIL reset_ack: got %b required 00", {ack0_o, ack1_o});
         end
         vectors++;
         if (rdata0_o !== 32'h0 || rdata1_o !== 32'h0) begin
            miscompares++; $display("[TB] FAIL reset_rdata: got %h/%h required 0/0", rdata0_o, rdata1_o);
         end
         vectors++;
         if (memAddr !== 32'h0) begin
            miscompares++; $display("[TB] FAIL reset_mem_addr: got %h required 0", memAddr);
         end
         advance();
      end
      rst_i = 1'b1;
   endtask

   task automatic test_solo_read();
      drive(0, 0, 0, 0, 1, 0, 32'd5, 0);
      predict();
      @(negedge clk_i);
      vectors++;
      if (gnt1_o !== 1'b1 || gnt0_o !== 1'b0) begin
         miscompares++; $display("[TB] FAIL solo_gnt: got gnt0=%b gnt1=%b required 0/1", gnt0_o, gnt1_o);
      end
      vectors++;
      if (memAddr !== 32'd5 || memWe !== 1'b0) begin
         miscompares++; $display("[TB] FAIL solo_bus: got addr=%h we=%b required 5/0", memAddr, memWe);
      end
      advance();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      predict();
      @(negedge clk_i);
      vectors++;
      if (ack1_o !== 1'b1 || rdata1_o !== 32'hDEADBEEF) begin
         miscompares++; $display("[TB] FAIL solo_ack: got ack1=%b rdata1=%h required 1/deadbeef", ack1_o, rdata1_o);
      end
      vectors++;
      if (memAddr !== 32'd5 || memWe !== 1'b0) begin
         miscompares++; $display("[TB] FAIL solo_hold: got addr=%h we=%b required 5/0", memAddr, memWe);
      end
      advance();
      predict();
      @(negedge clk_i);
      vectors++;
      if (ack1_o !== 1'b0 || rdata1_o !== 32'hDEADBEEF) begin
         miscompares++; $display("[TB] FAIL solo_ack_once: got ack1=%b rdata1=%h required 0/deadbeef", ack1_o, rdata1_o);
      end
      advance();
   endtask

   task automatic test_contention();
      int expWinner [6] = '{0, 0, 0, 0, 1, 0};
      drive(1, 0, 32'd20, 0, 1, 0, 32'd21, 0);
      for (int c = 0; c < 6; c++) begin
         predict();
         @(negedge clk_i);
         vectors++;
         if (gnt1_o !== (expWinner[c] == 1) || gnt0_o !== (expWinner[c] == 0)) begin
            miscompares++;
            $display("[TB] FAIL contention_c%0d: got gnt0=%b gnt1=%b required port %0d", c, gnt0_o, gnt1_o, expWinner[c]);
         end
         advance();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      predict();
      @(negedge clk_i);
      vectors++;
      if (ack0_o !== 1'b1 || rdata0_o !== refMem[20]) begin
         miscompares++; $display("[TB] FAIL contention_ack: got ack0=%b rdata0=%h required 1/%h", ack0_o, rdata0_o, refMem[20]);
      end
      advance();
   endtask

   task automatic test_back_to_back();
      drive(1, 1, 32'd10, 32'h1234, 0, 0, 0, 0);
      predict();
      @(negedge clk_i);
      vectors++;
      if (gnt0_o !== 1'b1 || memWe !== 1'b1 || memAddr !== 32'd10 || memWdata !== 32'h1234) begin
         miscompares++;
         $display("[TB] FAIL b2b_write: got gnt0=%b we=%b addr=%h wdata=%h required 1/1/a/1234", gnt0_o, memWe, memAddr, memWdata);
      end
      advance();
      drive(1, 0, 32'd10, 32'h0, 0, 0, 0, 0);
      predict();
      @(negedge clk_i);
      vectors++;
      if (gnt0_o !== 1'b1 || ack0_o !== 1'b1 || memWe !== 1'b0) begin
         miscompares++; $display("[TB] FAIL b2b_read: got gnt0=%b ack0=%b we=%b required 1/1/0", gnt0_o, ack0_o, memWe);
      end
      advance();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      predict();
      @(negedge clk_i);
      vectors++;
      if (ack0_o !== 1'b1 || rdata0_o !== 32'h1234) begin
         miscompares++; $display("[TB] FAIL b2b_rdata: got ack0=%b rdata0=%h required 1/1234", ack0_o, rdata0_o);
      end
      advance();
   endtask

   task automatic test_reset_mid_op();
      drive(1, 1, 32'd3, 32'h55, 0, 0, 0, 0);
      predict();
      @(negedge clk_i);
      vectors++;
      if (gnt0_o !== 1'b1 || memWe !== 1'b1) begin
         miscompares++; $display("[TB] FAIL midrst_grant: got gnt0=%b we=%b required 1/1", gnt0_o, memWe);
      end
      advance();
      rst_i = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      predict();
      @(negedge clk_i);
      vectors++;
      if (ack0_o !== 1'b0) begin
         miscompares++; $display("[TB] FAIL midrst_ack: got %b required 0", ack0_o);
      end
      vectors++;
      if (benchMem[3] !== 32'h55) begin
         miscompares++; $display("[TB] FAIL midrst_mem: got %h required 55", benchMem[3]);
      end
      advance();
      rst_i = 1'b1;
      drive(1, 0, 32'd3, 0, 1, 0, 32'd4, 0);
      predict();
      @(negedge clk_i);
      vectors++;
      if (ack0_o !== 1'b0 || gnt0_o !== 1'b1 || gnt1_o !== 1'b0) begin
         miscompares++; $display("[TB] FAIL postrst_arb: got ack0=%b gnt0=%b gnt1=%b required 0/1/0", ack0_o, gnt0_o, gnt1_o);
      end
      advance();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      predict();
      @(negedge clk_i);
      vectors++;
      if (rdata0_o !== 32'h55) begin
         miscompares++; $display("[TB] FAIL postrst_rdata: got %h required 55", rdata0_o);
      end
      advance();
   endtask

   task automatic test_starve_zero();
      drive(1, 0, 32'd8, 0, 1, 0, 32'd9, 0);
      for (int c = 0; c < 5; c++) begin
         predict();
         @(negedge clk_i);
         vectors++;
         if (gnt1Z !== 1'b1 || gnt0Z !== 1'b0) begin
            miscompares++; $display("[TB] FAIL starve0_c%0d: got gnt0=%b gnt1=%b required 0/1", c, gnt0Z, gnt1Z);
         end
         advance();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      predict();
      advance();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst_i = ($urandom_range(0, 29) != 0);
         drive($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, 32'($urandom_range(0, 63)), $urandom,
               $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, 32'($urandom_range(0, 63)), $urandom);
         predict();
         @(negedge clk_i);
         vectors++;
         if (gnt0_o !== eg0 || gnt1_o !== eg1) begin
            miscompares++; $display("[TB] FAIL rand_gnt_c%0d: got %b%b required %b%b", c, gnt0_o, gnt1_o, eg0, eg1);
         end
         vectors++;
         if (memWe !== eWe || memAddr !== eAddr || memWdata !== eWdata) begin
            miscompares++;
            $display("[TB] FAIL rand_bus_c%0d: got we=%b a=%h d=%h required we=%b a=%h d=%h", c, memWe, memAddr, memWdata, eWe, eAddr, eWdata);
         end
         vectors++;
         if (ack0_o !== eAck0 || ack1_o !== eAck1) begin
            miscompares++; $display("[TB] FAIL rand_ack_c%0d: got %b%b required %b%b", c, ack0_o, ack1_o, eAck0, eAck1);
         end
         vectors++;
         if (rdata0_o !== eRd0 || rdata1_o !== eRd1) begin
            miscompares++; $display("[TB] FAIL rand_rdata_c%0d: got %h/%h required %h/%h", c, rdata0_o, rdata1_o, eRd0, eRd1);
         end
         advance();
      end
      rst_i = 1'b1;
   endtask

   // Test sequence.
   initial begin
      logic [31:0] v;
      for (int i = 0; i < 256; i++) begin
         v = $urandom;
         benchMem[i] <= v;
         refMem[i] = v;
      end
      benchMem[5] <= 32'hDEADBEEF;
      refMem[5] = 32'hDEADBEEF;
      waitCnt = 0; prevG0 = 0; prevG1 = 0;
      eRd0 = '0; eRd1 = '0; eHeldA = '0; eHeldD = '0;
      rst_i = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      predict();
      advance();
      test_reset();
      test_solo_read();
      test_contention();
      test_back_to_back();
      test_reset_mid_op();
      test_starve_zero();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
